ring_rr_arbiter: RTL and testbench
==================================

# ring_rr_arbiter

Round-robin arbiter that shares one resource among N requesters. A one-hot rotating priority pointer drives it, stepping 1000 → 0100 → 0010 → 0001 → 1000 for N=4. The block sits in front of any shared sequential datapath and issues a registered one-hot grant. Each grant lasts until the owner drops its request or a hold-time limit expires. Handoff is back-to-back with no idle cycle.

## Interface
- N, 4, number of requesters; ≥2
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant; ≥1
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  N  request per requester, level-sensitive
- gnt  output  N  registered one-hot grant; all-zero when idle
- gnt_id  output  $clog2(N)  binary index of the current owner; 0 when idle
- busy  output  1  equals |gnt, registered
- expired  output  1  one-cycle pulse: the previous owner was released by timeout on this edge

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - ptr, N-bit one-hot priority pointer.
  - hold_cnt, $clog2(MAX_HOLD+1) bits.
- Priority search order:
  - Start at the index i where ptr[i]=1, then i-1, i-2, …, wrapping from 0 to N-1.
  - The first set req bit in that order wins.
- Reset (asynchronous, applies immediately, also mid-grant):
  - gnt=0, gnt_id=0, busy=0, expired=0.
  - ptr = 1<<(N-1) (1000 for N=4).
  - hold_cnt=0, state IDLE.
- IDLE:
  - If req≠0 at an edge: gnt = winner, gnt_id = its index, hold_cnt=0, go to GRANT.
  - Otherwise remain in IDLE.
- GRANT, owner o:
  - Continue: req[o]=1 and hold_cnt<MAX_HOLD-1 → hold_cnt+1, gnt unchanged.
  - Release by drop: req[o]=0.
  - Release by timeout: req[o]=1 and hold_cnt==MAX_HOLD-1. Set expired=1 for that cycle.
- On any release:
  - ptr = one-hot of (o-1 mod N), i.e. the owner rotated right, so the owner becomes lowest priority.
  - Arbitrate on the same edge using the new ptr and the current req.
  - If a winner exists: gnt = winner, hold_cnt=0, stay in GRANT. A timed-out owner that is the sole requester is re-granted.
  - If no winner: gnt=0, go to IDLE.
- Non-owner req changes during GRANT are ignored until the next release.
- ptr changes only on release. It never changes in IDLE.

## Timing
- Grant latency: req sampled at edge k → gnt valid after edge k. That is one cycle, with no combinational req→gnt path.
- Release latency: req[o] sampled low at edge k → gnt changes at edge k. gnt therefore stays high one cycle after req falls.
- A continuous grant spans at most MAX_HOLD cycles per owner before arbitration.
- Handoff is gapless: the old owner's last cycle is immediately followed by the new owner's first cycle.
- expired is high exactly one cycle and coincides with the new grant's first cycle.
- busy and gnt_id change on the same edge as gnt.

## Structure
- Package ring_arb_pkg holds:
  - the FSM state enum (IDLE, GRANT);
  - the default N and MAX_HOLD constants;
  - function rotate_right(onehot);
  - function onehot_to_idx.
- Sub-module ring_prio_pick is the combinational picker:
  - Inputs: ptr, req.
  - Outputs: win_onehot, win_valid.
  - It is instantiated once and fed with either the current ptr (IDLE) or the rotated ptr (release).
- The top level holds the FSM, the ptr register, hold_cnt and the output registers.

## Test plan
All scenarios use N=4, MAX_HOLD=4.
- **Reset:** rst=1 with req=1111 → gnt=0000, busy=0, expired=0. After rst falls with req=0000 → stays IDLE, gnt=0000.
- **Single request:** req=0010 at edge k → gnt=0010, gnt_id=1 after k. req drops → gnt=0000 one edge later. The next request req=1001 then grants 0001, because ptr is now 0001.
- **Full load:** req=1111 held 16 cycles → gnt sequence 1000, 0100, 0010, 0001, each held 4 cycles, no gaps, expired pulse at every handoff.
- **Lone requester timeout:** req=0100 held 10 cycles → gnt=0100 continuously, expired pulses on cycles 5 and 9, gnt_id=2 throughout.
- **Drop handoff:** owner 1000 drops while req=0101 → next gnt=0100 with expired=0. That owner drops with req=0001 → gnt=0001.
- **Async reset mid-grant:** assert rst between edges while gnt=0010 → gnt=0000 and busy=0 before the next edge. After release, ptr=1000, so req=1111 grants 1000 first.

Source files
------------

// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types, default parameters and one-hot helpers for the ring round-robin arbiter.
package ring_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 8;
    // Helpers work on a fixed-width container; callers zero-extend and truncate to N bits.
    localparam int MAX_N        = 32;

    function automatic logic [MAX_N-1:0] rotate_right(input logic [MAX_N-1:0] onehot, input int n);
        logic [MAX_N-1:0] r;
        r      = onehot >> 1;
        r[n-1] = onehot[0];
        return r;
    endfunction

    function automatic int onehot_to_idx(input logic [MAX_N-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            idx = onehot[i] ? i : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the ring arbiter (slave).
interface ring_rr_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           expired;

    modport master (output req, input gnt, input gnt_id, input busy, input expired);
    modport slave  (input req, output gnt, output gnt_id, output busy, output expired);
endinterface

// File: rtl/ring_rr_arbiter_prio_pick.sv
// Combinational picker: scans req downward from the pointer position, wrapping, first hit wins.
module ring_prio_pick
    import ring_arb_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0] ptr,
    input  logic [N-1:0] req,
    output logic [N-1:0] win_onehot,
    output logic         win_valid
);
    localparam int IDW = $clog2(N);

    int             start_s;
    logic [IDW-1:0] idx_s;
    logic           found_s;

    // Walk the ring from the pointer toward lower indices and take the first requester.
    always_comb begin
        win_onehot = {N{1'b0}};
        found_s    = 1'b0;
        idx_s      = {IDW{1'b0}};
        start_s    = onehot_to_idx(MAX_N'(ptr));
        for (int k = 0; k < N; k++) begin
            idx_s = IDW'((start_s - k + N) % N);
            if (!found_s && req[idx_s]) begin
                win_onehot[idx_s] = 1'b1;
                found_s           = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        win_valid = found_s;
    end
endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with rotating one-hot priority, hold-time limit and gapless handoff.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    ring_rr_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(MAX_HOLD + 1);

    arb_state_t     state_r, state_s;
    logic [N-1:0]   ptr_r, ptr_s;
    logic [HW-1:0]  hold_cnt_r, hold_cnt_s;
    logic [N-1:0]   gnt_r, gnt_s;
    logic [IDW-1:0] gnt_id_r;
    logic           busy_r;
    logic           expired_r, expired_s;

    logic           owner_req_s;
    logic           timeout_s;
    logic           release_s;
    logic [N-1:0]   rot_ptr_s;
    logic [N-1:0]   pick_ptr_s;
    logic [N-1:0]   win_s;
    logic           win_valid_s;

    assign owner_req_s = |(bus.req & gnt_r);
    assign timeout_s   = owner_req_s && (hold_cnt_r == HW'(MAX_HOLD - 1));
    assign release_s   = (state_r == GRANT) && (!owner_req_s || timeout_s);
    // The released owner becomes lowest priority: pointer sits one step below it.
    assign rot_ptr_s   = N'(rotate_right(MAX_N'(gnt_r), N));
    assign pick_ptr_s  = (state_r == GRANT) ? rot_ptr_s : ptr_r;

    ring_prio_pick #(.N(N)) u_pick (
        .ptr        (pick_ptr_s),
        .req        (bus.req),
        .win_onehot (win_s),
        .win_valid  (win_valid_s)
    );

    // Next-state logic: grant from idle, hold or release-and-rearbitrate in grant.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        gnt_s      = gnt_r;
        expired_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_valid_s) begin
                    gnt_s      = win_s;
                    hold_cnt_s = {HW{1'b0}};
                    state_s    = GRANT;
                end else begin
                    gnt_s      = {N{1'b0}};
                end
            end
            GRANT: begin
                if (release_s) begin
                    ptr_s      = rot_ptr_s;
                    expired_s  = timeout_s;
                    hold_cnt_s = {HW{1'b0}};
                    if (win_valid_s) begin
                        gnt_s   = win_s;
                        state_s = GRANT;
                    end else begin
                        gnt_s   = {N{1'b0}};
                        state_s = IDLE;
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + HW'(1);
                end
            end
            default: begin
                state_s    = IDLE;
                gnt_s      = {N{1'b0}};
                hold_cnt_s = {HW{1'b0}};
            end
        endcase
    end

    // State and registered outputs; async reset clears everything and parks ptr at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= {1'b1, {(N-1){1'b0}}};
            hold_cnt_r <= {HW{1'b0}};
            gnt_r      <= {N{1'b0}};
            gnt_id_r   <= {IDW{1'b0}};
            busy_r     <= 1'b0;
            expired_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
            gnt_r      <= gnt_s;
            gnt_id_r   <= IDW'(onehot_to_idx(MAX_N'(gnt_s)));
            busy_r     <= |gnt_s;
            expired_r  <= expired_s;
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.gnt_id  = gnt_id_r;
    assign bus.busy    = busy_r;
    assign bus.expired = expired_r;
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Randomized bench for ring_rr_arbiter against an owner/priority-index reference model.
module tb_ring_rr_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ring_rr_arbiter_if #(.N(N)) bus ();

    ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: owner index (-1 idle), priority index, cycles held so far.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_exp;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int search(input int start, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(start - k + N) % N]) return (start - k + N) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_held  = 0;
        m_exp   = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] r);
        m_exp = 1'b0;
        if (m_owner < 0) begin
            m_owner = search(m_ptr, r);
            m_held  = 1;
        end else if (r[m_owner] && m_held < MAX_HOLD) begin
            m_held++;
        end else begin
            m_exp   = r[m_owner];
            m_ptr   = (m_owner + N - 1) % N;
            m_owner = search(m_ptr, r);
            m_held  = 1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
        check_eq({tag, "_gnt"}, 32'(bus.gnt), 32'(eg));
        check_eq({tag, "_id"}, 32'(bus.gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'(m_owner >= 0));
        check_eq({tag, "_exp"}, 32'(bus.expired), 32'(m_exp));
    endtask

    // Apply req, clock one edge, advance the model and compare 1 ns after the edge.
    task automatic step(input logic [N-1:0] r, input string tag);
        bus.req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_exp", 32'(bus.expired), 32'd0);
        model_reset();
        bus.req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic mid_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_eq({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_id"}, 32'(bus.gnt_id), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [N-1:0] rq;

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        bus.req = '0;
        model_reset();
        #2;
        do_reset();
        step(4'b0000, "idle");
        step(4'b0000, "idle");

        // Single request, drop, then pointer now favours requester 0.
        step(4'b0010, "single");
        check_eq("single_gnt_lit", 32'(bus.gnt), 32'h2);
        check_eq("single_id_lit", 32'(bus.gnt_id), 32'd1);
        step(4'b0000, "single_drop");
        step(4'b1001, "single_next");
        check_eq("single_next_lit", 32'(bus.gnt), 32'h1);
        step(4'b0000, "single_clr");

        // Full load from reset: 4-cycle slots 1000,0100,0010,0001 with expiry at each handoff.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            step(4'b1111, "full");
            check_eq("full_lit", 32'(bus.gnt), 32'(4'b1000 >> (c / 4)));
        end
        step(4'b0000, "full_clr");

        // Lone requester keeps the grant across timeouts.
        for (int c = 1; c <= 10; c++) begin
            step(4'b0100, "lone");
            check_eq("lone_exp_lit", 32'(bus.expired), 32'(c == 5 || c == 9));
            check_eq("lone_id_lit", 32'(bus.gnt_id), 32'd2);
        end
        step(4'b0000, "lone_clr");

        // Drop handoff without expiry.
        do_reset();
        step(4'b1000, "drop_a");
        step(4'b0101, "drop_b");
        check_eq("drop_b_lit", 32'(bus.gnt), 32'h4);
        step(4'b0001, "drop_c");
        check_eq("drop_c_lit", 32'(bus.gnt), 32'h1);
        step(4'b0000, "drop_clr");

        // Async reset between edges while granted, then pointer back at the top.
        do_reset();
        step(4'b0010, "async_a");
        mid_reset("async");
        step(4'b1111, "async_b");
        check_eq("async_b_lit", 32'(bus.gnt), 32'h8);

        // Random sticky requests with occasional asynchronous resets.
        rq = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) rq = rq ^ N'($urandom_range(0, 15));
            if ($urandom_range(0, 30) == 0) rq = 4'b0000;
            step(rq, "rand");
            if ($urandom_range(0, 79) == 0) mid_reset("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
